// File: rtl/l15_transducer_req_queue.sv
// Request FIFO and flow-control stage in front of the L1.5 transducer port.
// Buffers core requests, presents the head entry and throttles on outstanding responses.
module l15_transducer_req_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int THREADID_W      = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  core_req_val,
  output logic                  core_req_rdy,
  input  logic [4:0]            core_req_rqtype,
  input  logic                  core_req_nc,
  input  logic [2:0]            core_req_size,
  input  logic [THREADID_W-1:0] core_req_threadid,
  input  logic [39:0]           core_req_address,
  input  logic [63:0]           core_req_data,

  output logic                  transducer_l15_val,
  output logic [4:0]            transducer_l15_rqtype,
  output logic                  transducer_l15_nc,
  output logic [2:0]            transducer_l15_size,
  output logic [THREADID_W-1:0] transducer_l15_threadid,
  output logic [39:0]           transducer_l15_address,
  output logic [63:0]           transducer_l15_data,
  output logic [63:0]           transducer_l15_data_next_entry,
  output logic [3:0]            transducer_l15_amo_op,
  output logic                  transducer_l15_prefetch,
  output logic                  transducer_l15_invalidate_cacheline,
  output logic                  transducer_l15_blockstore,
  output logic                  transducer_l15_blockinitstore,
  output logic [1:0]            transducer_l15_l1rplway,
  output logic [32:0]           transducer_l15_csm_data,

  input  logic                  l15_transducer_ack,
  input  logic                  l15_transducer_header_ack,
  input  logic                  l15_transducer_val,
  input  logic [3:0]            l15_transducer_returntype,
  output logic                  transducer_l15_req_ack,

  output logic [3:0]            outstanding_cnt,
  output logic                  resp_underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [4:0]            rqtype_mem   [DEPTH];
  logic                  nc_mem       [DEPTH];
  logic [2:0]            size_mem     [DEPTH];
  logic [THREADID_W-1:0] threadid_mem [DEPTH];
  logic [39:0]           address_mem  [DEPTH];
  logic [63:0]           data_mem     [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W:0]   count;

  logic enq;
  logic deq;
  logic issue_en;
  logic counted_rsp;
  logic unused_header_ack;

  assign unused_header_ack = l15_transducer_header_ack;

  assign core_req_rdy = (count != (PTR_W+1)'(DEPTH));
  assign enq          = core_req_val && core_req_rdy;
  assign issue_en     = (count != '0) && (outstanding_cnt < 4'(MAX_OUTSTANDING));
  assign deq          = l15_transducer_ack && issue_en;

  // Unsolicited invalidations (3) and interrupts (7) never consume an outstanding slot.
  assign counted_rsp = l15_transducer_val &&
                       (l15_transducer_returntype != 4'd3) &&
                       (l15_transducer_returntype != 4'd7);

  assign transducer_l15_req_ack = l15_transducer_val;
  assign transducer_l15_val     = issue_en;

  assign transducer_l15_rqtype   = rqtype_mem[rd_ptr];
  assign transducer_l15_nc       = nc_mem[rd_ptr];
  assign transducer_l15_size     = size_mem[rd_ptr];
  assign transducer_l15_threadid = threadid_mem[rd_ptr];
  assign transducer_l15_address  = address_mem[rd_ptr];
  assign transducer_l15_data     = data_mem[rd_ptr];

  assign next_ptr = rd_ptr + 1'b1;
  assign transducer_l15_data_next_entry =
    (count >= (PTR_W+1)'(2)) ? data_mem[next_ptr] : 64'd0;

  assign transducer_l15_amo_op               = 4'd0;
  assign transducer_l15_prefetch             = 1'b0;
  assign transducer_l15_invalidate_cacheline = 1'b0;
  assign transducer_l15_blockstore           = 1'b0;
  assign transducer_l15_blockinitstore       = 1'b0;
  assign transducer_l15_l1rplway             = 2'd0;
  assign transducer_l15_csm_data             = 33'd0;

  // Payload storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      rqtype_mem[wr_ptr]   <= core_req_rqtype;
      nc_mem[wr_ptr]       <= core_req_nc;
      size_mem[wr_ptr]     <= core_req_size;
      threadid_mem[wr_ptr] <= core_req_threadid;
      address_mem[wr_ptr]  <= core_req_address;
      data_mem[wr_ptr]     <= core_req_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
    end
  end

  // A counted response with nothing in flight is a protocol error: saturate and flag it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_cnt    <= 4'd0;
      resp_underflow_err <= 1'b0;
    end else begin
      if (deq && !counted_rsp) begin
        outstanding_cnt <= outstanding_cnt + 4'd1;
      end else if (!deq && counted_rsp) begin
        if (outstanding_cnt == 4'd0) resp_underflow_err <= 1'b1;
        else                         outstanding_cnt    <= outstanding_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_l15_transducer_req_queue.sv
// Directed, table-driven bench for l15_transducer_req_queue (DEPTH=4, MAX_OUTSTANDING=2).
module tb_l15_transducer_req_queue;

  logic        clk;
  logic        rst;
  logic        core_req_val;
  logic        core_req_rdy;
  logic [4:0]  core_req_rqtype;
  logic        core_req_nc;
  logic [2:0]  core_req_size;
  logic [0:0]  core_req_threadid;
  logic [39:0] core_req_address;
  logic [63:0] core_req_data;
  logic        transducer_l15_val;
  logic [4:0]  transducer_l15_rqtype;
  logic        transducer_l15_nc;
  logic [2:0]  transducer_l15_size;
  logic [0:0]  transducer_l15_threadid;
  logic [39:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic [63:0] transducer_l15_data_next_entry;
  logic [3:0]  transducer_l15_amo_op;
  logic        transducer_l15_prefetch;
  logic        transducer_l15_invalidate_cacheline;
  logic        transducer_l15_blockstore;
  logic        transducer_l15_blockinitstore;
  logic [1:0]  transducer_l15_l1rplway;
  logic [32:0] transducer_l15_csm_data;
  logic        l15_transducer_ack;
  logic        l15_transducer_header_ack;
  logic        l15_transducer_val;
  logic [3:0]  l15_transducer_returntype;
  logic        transducer_l15_req_ack;
  logic [3:0]  outstanding_cnt;
  logic        resp_underflow_err;

  int n_compared;
  int n_mismatched;

  l15_transducer_req_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .THREADID_W(1)) dut (
    .clk                                 (clk),
    .rst                                 (rst),
    .core_req_val                        (core_req_val),
    .core_req_rdy                        (core_req_rdy),
    .core_req_rqtype                     (core_req_rqtype),
    .core_req_nc                         (core_req_nc),
    .core_req_size                       (core_req_size),
    .core_req_threadid                   (core_req_threadid),
    .core_req_address                    (core_req_address),
    .core_req_data                       (core_req_data),
    .transducer_l15_val                  (transducer_l15_val),
    .transducer_l15_rqtype               (transducer_l15_rqtype),
    .transducer_l15_nc                   (transducer_l15_nc),
    .transducer_l15_size                 (transducer_l15_size),
    .transducer_l15_threadid             (transducer_l15_threadid),
    .transducer_l15_address              (transducer_l15_address),
    .transducer_l15_data                 (transducer_l15_data),
    .transducer_l15_data_next_entry      (transducer_l15_data_next_entry),
    .transducer_l15_amo_op               (transducer_l15_amo_op),
    .transducer_l15_prefetch             (transducer_l15_prefetch),
    .transducer_l15_invalidate_cacheline (transducer_l15_invalidate_cacheline),
    .transducer_l15_blockstore           (transducer_l15_blockstore),
    .transducer_l15_blockinitstore       (transducer_l15_blockinitstore),
    .transducer_l15_l1rplway             (transducer_l15_l1rplway),
    .transducer_l15_csm_data             (transducer_l15_csm_data),
    .l15_transducer_ack                  (l15_transducer_ack),
    .l15_transducer_header_ack           (l15_transducer_header_ack),
    .l15_transducer_val                  (l15_transducer_val),
    .l15_transducer_returntype           (l15_transducer_returntype),
    .transducer_l15_req_ack              (transducer_l15_req_ack),
    .outstanding_cnt                     (outstanding_cnt),
    .resp_underflow_err                  (resp_underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req_val;
    logic [39:0] addr;
    logic        ack;
    logic        rsp_val;
    logic [3:0]  rtype;
    logic        exp_rdy;
    logic        exp_val;
    logic        chk_head;
    logic [39:0] exp_head;
    logic [39:0] exp_next;
    logic [3:0]  exp_ocnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  localparam logic [39:0] LD = 40'h00_8000_0040;
  localparam logic [39:0] A1 = 40'h100, A2 = 40'h200, A3 = 40'h300, A4 = 40'h400, A5 = 40'h500;
  localparam logic [39:0] B1 = 40'h900, C1 = 40'hC00, D1 = 40'hD00, D2 = 40'hE00, F1 = 40'hF00;

  // Payload fields are derived from the address so head checks cover the whole entry.
  function automatic logic [63:0] dat(input logic [39:0] a);
    return {24'hDA7A5E, a};
  endfunction

  function automatic logic [4:0] rqt(input logic [39:0] a);
    return {1'b0, a[11:8]};
  endfunction

  task automatic compare(input string what, input int row, input logic [63:0] act,
                         input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", what, row, act, exp);
    end
  endtask

  task automatic addVec(input logic rv, input logic [39:0] a, input logic ak, input logic sv,
                        input logic [3:0] rt, input logic er, input logic ev, input logic ch,
                        input logic [39:0] eh, input logic [39:0] en, input logic [3:0] eo,
                        input logic ee);
    vec_t v;
    v.req_val = rv; v.addr = a; v.ack = ak; v.rsp_val = sv; v.rtype = rt;
    v.exp_rdy = er; v.exp_val = ev; v.chk_head = ch; v.exp_head = eh;
    v.exp_next = en; v.exp_ocnt = eo; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    core_req_val              = v.req_val;
    core_req_address          = v.addr;
    core_req_data             = dat(v.addr);
    core_req_rqtype           = rqt(v.addr);
    core_req_nc               = v.addr[8];
    core_req_size             = v.addr[10:8];
    core_req_threadid         = v.addr[9];
    l15_transducer_ack        = v.ack;
    l15_transducer_val        = v.rsp_val;
    l15_transducer_returntype = v.rtype;
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    compare("core_req_rdy", row, 64'(core_req_rdy), 64'(v.exp_rdy));
    compare("l15_val", row, 64'(transducer_l15_val), 64'(v.exp_val));
    compare("outstanding_cnt", row, 64'(outstanding_cnt), 64'(v.exp_ocnt));
    compare("underflow_err", row, 64'(resp_underflow_err), 64'(v.exp_err));
    compare("req_ack", row, 64'(transducer_l15_req_ack), 64'(v.rsp_val));
    compare("data_next_entry", row, transducer_l15_data_next_entry,
            (v.exp_next == 40'd0) ? 64'd0 : dat(v.exp_next));
    if (v.chk_head) begin
      compare("head_address", row, 64'(transducer_l15_address), 64'(v.exp_head));
      compare("head_data", row, transducer_l15_data, dat(v.exp_head));
      compare("head_rqtype", row, 64'(transducer_l15_rqtype), 64'(rqt(v.exp_head)));
      compare("head_size", row, 64'(transducer_l15_size), 64'(v.exp_head[10:8]));
    end
  endtask

  task automatic runVec(input int row, input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(row, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    n_compared   = 0;
    n_mismatched = 0;
    l15_transducer_header_ack = 1'b0;
    idle = '{1'b0, 40'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 40'd0, 40'd0, 4'd0, 1'b0};
    applyStimulus(idle);

    //     rv  addr ak sv rt    rdy val chk head next ocnt err
    addVec(0,  0,   0, 0, 4'd0, 1,  0,  0,  0,   0,   0,   0); // 0 reset state
    addVec(1,  LD,  0, 0, 4'd0, 1,  0,  0,  0,   0,   0,   0); // 1 single load
    addVec(0,  0,   0, 0, 4'd0, 1,  1,  1,  LD,  0,   0,   0); // 2 visible next cycle
    addVec(0,  0,   1, 0, 4'd0, 1,  1,  1,  LD,  0,   0,   0); // 3 ack
    addVec(0,  0,   0, 1, 4'd0, 1,  0,  0,  0,   0,   1,   0); // 4 response type 0
    addVec(0,  0,   0, 1, 4'd7, 1,  0,  0,  0,   0,   0,   0); // 5 interrupt at 0: no error
    addVec(1,  A1,  0, 0, 4'd0, 1,  0,  0,  0,   0,   0,   0); // 6 fill
    addVec(1,  A2,  0, 0, 4'd0, 1,  1,  1,  A1,  0,   0,   0);
    addVec(1,  A3,  0, 0, 4'd0, 1,  1,  1,  A1,  A2,  0,   0);
    addVec(1,  A4,  0, 0, 4'd0, 1,  1,  1,  A1,  A2,  0,   0);
    addVec(1,  A5,  0, 0, 4'd0, 0,  1,  1,  A1,  A2,  0,   0); // 10 full, A5 stalls
    addVec(1,  A5,  1, 0, 4'd0, 0,  1,  1,  A1,  A2,  0,   0); // 11 one ack
    addVec(1,  A5,  0, 0, 4'd0, 1,  1,  1,  A2,  A3,  1,   0); // 12 rdy back, A5 enters
    addVec(0,  0,   0, 0, 4'd0, 0,  1,  1,  A2,  A3,  1,   0);
    addVec(0,  0,   1, 0, 4'd0, 0,  1,  1,  A2,  A3,  1,   0); // 14 second issue
    addVec(0,  0,   1, 0, 4'd0, 1,  0,  1,  A3,  A4,  2,   0); // 15 throttled, ack ignored
    addVec(0,  0,   0, 1, 4'd3, 1,  0,  1,  A3,  A4,  2,   0); // 16 evict not counted
    addVec(0,  0,   0, 1, 4'd7, 1,  0,  1,  A3,  A4,  2,   0);
    addVec(0,  0,   1, 1, 4'd4, 1,  0,  1,  A3,  A4,  2,   0); // 18 counted response
    addVec(0,  0,   1, 0, 4'd0, 1,  1,  1,  A3,  A4,  1,   0); // 19 third issue
    addVec(0,  0,   1, 1, 4'd0, 1,  0,  1,  A4,  A5,  2,   0);
    addVec(0,  0,   1, 1, 4'd2, 1,  1,  1,  A4,  A5,  1,   0); // 21 dequeue + response
    addVec(0,  0,   0, 0, 4'd0, 1,  1,  1,  A5,  0,   1,   0);
    addVec(1,  B1,  1, 1, 4'd0, 1,  1,  1,  A5,  0,   1,   0); // 23 enq+deq at count 1
    addVec(0,  0,   0, 0, 4'd0, 1,  1,  1,  B1,  0,   1,   0);
    addVec(0,  0,   1, 1, 4'd1, 1,  1,  1,  B1,  0,   1,   0);
    addVec(0,  0,   0, 1, 4'd0, 1,  0,  0,  0,   0,   1,   0);
    addVec(0,  0,   0, 1, 4'd5, 1,  0,  0,  0,   0,   0,   0); // 27 underflow
    addVec(0,  0,   0, 0, 4'd0, 1,  0,  0,  0,   0,   0,   1);
    addVec(1,  C1,  0, 0, 4'd0, 1,  0,  0,  0,   0,   0,   1);
    addVec(0,  0,   1, 0, 4'd0, 1,  1,  1,  C1,  0,   0,   1);
    addVec(0,  0,   0, 0, 4'd0, 1,  0,  0,  0,   0,   1,   1); // 31 error stays sticky

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    compare("const_zero_outputs", -1,
            64'({transducer_l15_amo_op, transducer_l15_prefetch,
                 transducer_l15_invalidate_cacheline, transducer_l15_blockstore,
                 transducer_l15_blockinitstore, transducer_l15_l1rplway,
                 transducer_l15_csm_data}), 64'd0);

    for (int i = 0; i < vecs.size(); i++) runVec(i, vecs[i]);

    // Asynchronous reset mid-burst, asserted between clock edges.
    idle.req_val = 1'b1; idle.addr = D1; applyStimulus(idle);
    @(posedge clk); #1;
    idle.addr = D2; applyStimulus(idle);
    @(posedge clk); #2;
    compare("pre_reset_val", 100, 64'(transducer_l15_val), 64'd1);
    rst = 1'b1;
    core_req_val = 1'b0;
    #1;
    compare("async_val", 100, 64'(transducer_l15_val), 64'd0);
    compare("async_rdy", 100, 64'(core_req_rdy), 64'd1);
    compare("async_ocnt", 100, 64'(outstanding_cnt), 64'd0);
    compare("async_err", 100, 64'(resp_underflow_err), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    compare("post_reset_val", 101, 64'(transducer_l15_val), 64'd0);
    compare("post_reset_rdy", 101, 64'(core_req_rdy), 64'd1);
    compare("post_reset_next", 101, transducer_l15_data_next_entry, 64'd0);
    @(posedge clk); #1;
    idle.req_val = 1'b1; idle.addr = F1; applyStimulus(idle);
    @(posedge clk); #1;
    core_req_val = 1'b0;
    l15_transducer_ack = 1'b1;
    @(negedge clk);
    compare("post_reset_head", 102, 64'(transducer_l15_address), 64'(F1));
    compare("post_reset_next2", 102, transducer_l15_data_next_entry, 64'd0);
    @(posedge clk); #1;
    l15_transducer_ack = 1'b0;
    @(negedge clk);
    compare("post_reset_ocnt", 103, 64'(outstanding_cnt), 64'd1);
    compare("post_reset_empty", 103, 64'(transducer_l15_val), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
